// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the CPU M-cycle bus responder: T-cycle codes,
// open-bus value, HRAM default base and the responder FSM state type.
package gb_bus_pkg;

  localparam logic [1:0] T1 = 2'b00;
  localparam logic [1:0] T2 = 2'b01;
  localparam logic [1:0] T3 = 2'b10;
  localparam logic [1:0] T4 = 2'b11;

  localparam logic [7:0]  OPEN_BUS          = 8'hFF;
  localparam logic [15:0] HRAM_BASE_DEFAULT = 16'hFF80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HRAM = 2'd1,
    EXT  = 2'd2
  } bus_state_e;

  // True when a lies in [base, base+depth); computed in int so base+depth may exceed 16 bits.
  function automatic logic in_window(input logic [15:0] a, input logic [15:0] base,
                                     input int depth);
    return (int'(a) >= int'(base)) && (int'(a) < int'(base) + depth);
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU-side and external-side bus bundle of mem_bus_responder.
// access_count only exists when ACCESS_COUNT_EN is defined.
interface mem_bus_responder_if;
  // CPU side: rd/wr with addr_bus sampled at the end of T3 while idle starts one access;
  // bus_wait high means the CPU must hold. External side: ext_req stays high with
  // ext_addr/ext_we/ext_wdata stable until a one-cycle ext_ack or the timeout.
  logic [1:0]  t_cycle;
  logic [15:0] addr_bus;
  logic        rd;
  logic        wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  data_bus_out;
  logic        bus_wait;
  logic        bus_err;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
`ifdef ACCESS_COUNT_EN
  logic [15:0] access_count;
`endif

  modport slave (
    input  t_cycle, addr_bus, rd, wr, cpu_wdata, ext_rdata, ext_ack,
`ifdef ACCESS_COUNT_EN
    output access_count,
`endif
    output data_bus_out, bus_wait, bus_err, ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output t_cycle, addr_bus, rd, wr, cpu_wdata, ext_rdata, ext_ack,
`ifdef ACCESS_COUNT_EN
    input  access_count,
`endif
    input  data_bus_out, bus_wait, bus_err, ext_req, ext_we, ext_addr, ext_wdata
  );

endinterface

// File: rtl/mem_bus_responder_hram_bank.sv
// Single-port byte RAM with registered read; contents are never reset.
module hram_bank #(
  parameter int DEPTH = 127,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: serves HRAM locally, forwards other addresses to an
// ack-handshaked external port with timeout. Optional ACCESS_COUNT_EN adds access_count.
module mem_bus_responder
  import gb_bus_pkg::*;
#(
  parameter logic [15:0] HRAM_BASE   = HRAM_BASE_DEFAULT,
  parameter int          HRAM_DEPTH  = 127,
  parameter int          EXT_TIMEOUT = 6
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_responder_if.slave  bus,
  output bus_state_e          dbg_state
);

  localparam int AW = $clog2(HRAM_DEPTH);
  localparam int CW = $clog2(EXT_TIMEOUT + 1);

  bus_state_e    state, state_next;
  logic          sample, conflict, access, hit, timeout, ack;
  logic [AW-1:0] offset, off_q;
  logic          we_q;
  logic [7:0]    wdata_q, data_q, ram_rdata;
  logic          err_q;
  logic [15:0]   ext_addr_q;
  logic [7:0]    ext_wdata_q;
  logic [CW-1:0] tcnt;

  assign sample   = (state == IDLE) && (bus.t_cycle == T3);
  assign conflict = sample && bus.rd && bus.wr;
  assign access   = sample && (bus.rd ^ bus.wr);
  assign hit      = in_window(bus.addr_bus, HRAM_BASE, HRAM_DEPTH);
  assign offset   = AW'(bus.addr_bus - HRAM_BASE);
  assign ack      = (state == EXT) && bus.ext_ack;
  // An ack on the last allowed cycle completes normally instead of timing out.
  assign timeout  = (state == EXT) && !bus.ext_ack && (tcnt == CW'(EXT_TIMEOUT - 1));

  // Reads are issued at the sampling edge so data is visible in T4; writes commit in HRAM.
  hram_bank #(.DEPTH(HRAM_DEPTH), .AW(AW)) u_hram (
    .clk   (clk),
    .en    ((access && hit && bus.rd) || (state == HRAM && we_q)),
    .we    (state == HRAM),
    .addr  ((state == HRAM) ? off_q : offset),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (access) state_next = hit ? HRAM : EXT;
      HRAM:    state_next = IDLE;
      EXT:     if (ack || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q      <= OPEN_BUS;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      off_q       <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      tcnt        <= '0;
    end else begin
      err_q <= conflict || timeout;
      if (conflict || timeout)         data_q <= OPEN_BUS;
      else if (state == HRAM && !we_q) data_q <= ram_rdata;
      else if (ack && !we_q)           data_q <= bus.ext_rdata;
      if (access) begin
        we_q    <= bus.wr;
        wdata_q <= bus.cpu_wdata;
        off_q   <= offset;
        if (!hit) begin
          ext_addr_q  <= bus.addr_bus;
          ext_wdata_q <= bus.cpu_wdata;
        end
      end
      if (state == EXT && !ack && !timeout) tcnt <= tcnt + 1'b1;
      else                                  tcnt <= '0;
    end
  end

`ifdef ACCESS_COUNT_EN
  logic [15:0] count_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       count_q <= '0;
    else if (state == HRAM || ack)  count_q <= count_q + 16'd1;
  end
  assign bus.access_count = count_q;
`endif

  always_comb begin
    bus.ext_req      = (state == EXT);
    bus.bus_wait     = (state == EXT);
    bus.ext_we       = (state == EXT) && we_q;
    bus.ext_addr     = ext_addr_q;
    bus.ext_wdata    = ext_wdata_q;
    bus.bus_err      = err_q;
    bus.data_bus_out = (state == HRAM && !we_q) ? ram_rdata : data_q;
    dbg_state        = state;
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: transaction-level model, per-cycle compare,
// directed scenarios and randomized M-cycles.
module tb_mem_bus_responder;
  import gb_bus_pkg::*;

  localparam logic [15:0] BASE  = 16'hFF80;
  localparam int          DEPTH = 127;
  localparam int          TMO   = 6;
  localparam int          NEVER = 255;

  logic       clk = 1'b0;
  logic       rst;
  bus_state_e dbg_state;

  mem_bus_responder_if bus();

  mem_bus_responder #(.HRAM_BASE(BASE), .HRAM_DEPTH(DEPTH), .EXT_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [DEPTH];
  bit          m_valid [DEPTH];
  logic [7:0]  m_data;
  bit          m_known, m_err, m_busy, m_we, m_pend, m_pend_we;
  int          m_cycles, m_pend_off;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_pend_val;
  logic [15:0] m_count;

  function automatic void model_reset();
    m_data = 8'hFF; m_known = 1; m_err = 0; m_busy = 0; m_we = 0; m_pend = 0;
    m_pend_we = 0; m_cycles = 0; m_addr = '0; m_wdata = '0; m_count = '0;
  endfunction

  function automatic void model_step();
    int off;
    m_err = 0;
    if (m_busy) begin
      m_cycles++;
      if (bus.ext_ack) begin
        if (!m_we) begin m_data = bus.ext_rdata; m_known = 1; end
        m_busy = 0;
        m_count++;
      end else if (m_cycles == TMO) begin
        m_busy = 0; m_data = 8'hFF; m_known = 1; m_err = 1;
      end
    end else if (m_pend) begin
      if (m_pend_we) begin m_mem[m_pend_off] = m_pend_val; m_valid[m_pend_off] = 1; end
      m_pend = 0;
      m_count++;
    end else if (bus.t_cycle == 2'b10 && (bus.rd || bus.wr)) begin
      off = int'(bus.addr_bus) - int'(BASE);
      if (bus.rd && bus.wr) begin
        m_err = 1; m_data = 8'hFF; m_known = 1;
      end else if (off >= 0 && off < DEPTH) begin
        m_pend = 1; m_pend_we = bus.wr; m_pend_off = off; m_pend_val = bus.cpu_wdata;
        if (bus.rd) begin m_data = m_mem[off]; m_known = m_valid[off]; end
      end else begin
        m_busy = 1; m_cycles = 0; m_we = bus.wr;
        m_addr = bus.addr_bus; m_wdata = bus.cpu_wdata;
      end
    end
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  int req_run = 0, last_run = 0, req_seen = 0, err_pulses = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (m_known) check("data_bus_out", 32'(bus.data_bus_out), 32'(m_data));
        check("bus_err",   32'(bus.bus_err),   32'(m_err));
        check("ext_req",   32'(bus.ext_req),   32'(m_busy));
        check("bus_wait",  32'(bus.bus_wait),  32'(m_busy));
        check("ext_we",    32'(bus.ext_we),    32'(m_busy && m_we));
        check("ext_addr",  32'(bus.ext_addr),  32'(m_addr));
        check("ext_wdata", 32'(bus.ext_wdata), 32'(m_wdata));
`ifdef ACCESS_COUNT_EN
        check("access_count", 32'(bus.access_count), 32'(m_count));
`endif
      end
      if (bus.ext_req) begin req_run++; req_seen++; end
      else begin
        if (req_run > 0) last_run = req_run;
        req_run = 0;
      end
      if (bus.bus_err) err_pulses++;
    end
  end

  // ---------------- external responder ----------------
  int         ack_delay = 3;
  logic [7:0] ack_data = 8'h00;
  bit         late_ack = 0;

  initial begin
    int  wcnt;
    bit  acked;
    wcnt = 0; acked = 0;
    bus.ext_ack = 1'b0; bus.ext_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.ext_ack = 1'b0;
      if (late_ack) begin
        bus.ext_ack = 1'b1; bus.ext_rdata = 8'hA5; late_ack = 0;
      end else if (rst && bus.ext_req) begin
        if (!acked) begin
          wcnt++;
          if (wcnt == ack_delay) begin
            bus.ext_ack = 1'b1; bus.ext_rdata = ack_data; acked = 1;
          end
        end
      end else begin
        wcnt = 0; acked = 0;
      end
    end
  end

  // ---------------- CPU driver ----------------
  logic [7:0] t4_data;
  int         stall;

  task automatic mcycle(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); bus.t_cycle = T1; bus.rd = 0; bus.wr = 0;
    @(negedge clk); bus.t_cycle = T2; bus.addr_bus = a; bus.rd = r; bus.wr = w; bus.cpu_wdata = d;
    @(negedge clk); bus.t_cycle = T3;
    @(negedge clk); bus.t_cycle = T4;
    #1; t4_data = bus.data_bus_out;
    stall = 0;
    while (bus.bus_wait && stall < 40) begin
      stall++;
      @(negedge clk); #1;
    end
    check("bus_wait_released", 32'(bus.bus_wait), 32'd0);
    #1;
  endtask

  initial begin
    int e0, r0;
`ifdef ACCESS_COUNT_EN
    logic [15:0] c0;
`endif
    rst = 1'b1;
    bus.t_cycle = T1; bus.addr_bus = '0; bus.rd = 0; bus.wr = 0; bus.cpu_wdata = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data",      32'(bus.data_bus_out), 32'hFF);
    check("rst_err",       32'(bus.bus_err),      32'd0);
    check("rst_req",       32'(bus.ext_req),      32'd0);
    check("rst_wait",      32'(bus.bus_wait),     32'd0);
    check("rst_we",        32'(bus.ext_we),       32'd0);
    check("rst_ext_addr",  32'(bus.ext_addr),     32'd0);
    check("rst_ext_wdata", 32'(bus.ext_wdata),    32'd0);
    check("rst_state",     32'(dbg_state),        32'(IDLE));
`ifdef ACCESS_COUNT_EN
    check("rst_count",     32'(bus.access_count), 32'd0);
`endif
    rst = 1'b1;

    // HRAM write then read back in T4, never touching the external port
    r0 = req_seen;
    mcycle(0, 1, 16'hFF80, 8'h5A);
    mcycle(1, 0, 16'hFF80, 8'h00);
    check("hram_t4_data", 32'(t4_data), 32'h5A);
    check("hram_no_req",  32'(req_seen - r0), 32'd0);

    // external read, ack after three cycles
    ack_delay = 3; ack_data = 8'h3C; e0 = err_pulses;
    mcycle(1, 0, 16'hC000, 8'h00);
    check("ext_req_len",  32'(last_run), 32'd3);
    check("ext_wait_len", 32'(stall), 32'd3);
    check("ext_rd_data",  32'(bus.data_bus_out), 32'h3C);
    check("ext_no_err",   32'(err_pulses - e0), 32'd0);

    // timeout, then a late ack that must be ignored
    ack_delay = NEVER; e0 = err_pulses;
    mcycle(1, 0, 16'h8000, 8'h00);
    check("tmo_req_len", 32'(last_run), 32'd6);
    check("tmo_data",    32'(bus.data_bus_out), 32'hFF);
    check("tmo_err",     32'(err_pulses - e0), 32'd1);
    late_ack = 1;
    repeat (3) @(negedge clk);
    #2;
    check("late_ack_data", 32'(bus.data_bus_out), 32'hFF);
    check("late_ack_err",  32'(err_pulses - e0), 32'd1);

    // ack on the timeout cycle wins
    ack_delay = 6; ack_data = 8'h77; e0 = err_pulses;
    mcycle(1, 0, 16'h4000, 8'h00);
    check("ack_at_tmo_data", 32'(bus.data_bus_out), 32'h77);
    check("ack_at_tmo_err",  32'(err_pulses - e0), 32'd0);

    // rd+wr conflict: error, open bus, HRAM untouched
    mcycle(0, 1, 16'hFF90, 8'h11);
    e0 = err_pulses; r0 = req_seen;
    mcycle(1, 1, 16'hFF90, 8'h22);
    check("conf_data", 32'(bus.data_bus_out), 32'hFF);
    check("conf_err",  32'(err_pulses - e0), 32'd1);
    check("conf_req",  32'(req_seen - r0), 32'd0);
    mcycle(1, 0, 16'hFF90, 8'h00);
    check("conf_hram_kept", 32'(t4_data), 32'h11);

    // window boundaries
    r0 = req_seen;
    mcycle(0, 1, 16'hFFFE, 8'hC3);
    mcycle(1, 0, 16'hFFFE, 8'h00);
    check("top_hram_data", 32'(t4_data), 32'hC3);
    check("top_hram_req",  32'(req_seen - r0), 32'd0);
    ack_delay = 2; ack_data = 8'h9E;
    mcycle(1, 0, 16'hFFFF, 8'h00);
    check("ffff_is_ext", 32'(req_seen - r0), 32'd2);
    check("ffff_data",   32'(bus.data_bus_out), 32'h9E);

    // external write leaves data_bus_out alone
    mcycle(0, 1, 16'h1234, 8'hAB);
    check("ext_wr_hold", 32'(bus.data_bus_out), 32'h9E);

    // asynchronous reset in the middle of an external access
    ack_delay = NEVER;
    @(negedge clk); bus.t_cycle = T1;
    @(negedge clk); bus.t_cycle = T2; bus.addr_bus = 16'h8000; bus.rd = 1; bus.wr = 0;
    @(negedge clk); bus.t_cycle = T3;
    @(negedge clk); bus.t_cycle = T4;
    @(negedge clk); #2;
    check("mid_req_before", 32'(bus.ext_req), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_req",  32'(bus.ext_req),      32'd0);
    check("mid_rst_wait", 32'(bus.bus_wait),     32'd0);
    check("mid_rst_data", 32'(bus.data_bus_out), 32'hFF);
    @(negedge clk); bus.rd = 0;
    #1 rst = 1'b1;
    ack_delay = 2; ack_data = 8'h42;
    mcycle(1, 0, 16'hC000, 8'h00);
    check("post_rst_data", 32'(bus.data_bus_out), 32'h42);

`ifdef ACCESS_COUNT_EN
    c0 = bus.access_count;
    mcycle(0, 1, 16'hFF81, 8'h01);
    mcycle(1, 0, 16'hFF81, 8'h00);
    ack_delay = 1;
    mcycle(1, 0, 16'h2000, 8'h00);
    ack_delay = NEVER;
    mcycle(1, 0, 16'h2001, 8'h00);
    check("count_delta", 32'(bus.access_count - c0), 32'd3);
`endif

    // randomized M-cycles
    for (int i = 0; i < 200; i++) begin
      int k, sel;
      logic r, w;
      logic [15:0] a;
      logic [15:0] edges [4];
      edges[0] = 16'hFF7F; edges[1] = 16'hFF80; edges[2] = 16'hFFFE; edges[3] = 16'hFFFF;
      k = $urandom_range(0, 99);
      if (k < 8)       begin r = 1; w = 1; end
      else if (k < 13) begin r = 0; w = 0; end
      else             begin r = 1'($urandom_range(0, 1)); w = !r; end
      sel = $urandom_range(0, 9);
      if (sel < 5)       a = BASE + 16'($urandom_range(0, 15));
      else if (sel == 5) a = edges[$urandom_range(0, 3)];
      else               a = 16'($urandom);
      ack_delay = $urandom_range(1, 8);
      ack_data  = 8'($urandom);
      mcycle(r, w, a, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
